// File: rtl/addchain_sched.sv
// addchain_sched: two-requester round-robin scheduler sharing one adder over STEPS-addition jobs.
// Define ADDCHAIN_OVF_EN to add the sticky carry-out report on out_ovf.
module addchain_sched #(
  parameter int WIDTH = 32,
  parameter int STEPS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_id,
`ifdef ADDCHAIN_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, op_x, op_y, sel_a, sel_b;
  logic [WIDTH:0] sum;
  logic [7:0] cnt_q, cnt_d;
  logic id_q, id_d, ptr_q, ptr_d, gnt0, gnt1, gnt;
  // ptr_q holds the last served requester; the other one wins a tie
  always_comb begin
    gnt0 = state_q == IDLE && !rst && req0_valid && (!req1_valid || ptr_q);
    gnt1 = state_q == IDLE && !rst && req1_valid && (!req0_valid || !ptr_q);
    gnt = gnt0 | gnt1;
    sel_a = gnt1 ? req1_a : req0_a;
    sel_b = gnt1 ? req1_b : req0_b;
    op_x = state_q == IDLE ? sel_a : acc_q;
    op_y = state_q == IDLE ? sel_b : (cnt_q[0] ? a_q : b_q);
    sum = {1'b0, op_x} + {1'b0, op_y};
    state_d = state_q;
    a_d = gnt ? sel_a : a_q;
    b_d = gnt ? sel_b : b_q;
    id_d = gnt ? gnt1 : id_q;
    ptr_d = gnt ? gnt1 : ptr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (gnt) begin
      state_d = RUN;
      acc_d = sum[WIDTH-1:0];
      cnt_d = 8'd1;
    end else if (state_q == RUN) begin
      acc_d = sum[WIDTH-1:0];
      cnt_d = cnt_q + 8'd1;
      state_d = cnt_q == 8'(STEPS - 1) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      id_q <= 1'b0;
      ptr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef ADDCHAIN_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = gnt ? sum[WIDTH] : (state_q == RUN ? ovf_q | sum[WIDTH] : ovf_q);
  always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf_d;
  assign out_ovf = ovf_q;
`endif
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_sum = acc_q;
  assign out_id = id_q;
endmodule

// File: doc/addchain_sched.md
ADDCHAIN_SCHED -- requirements
Module: addchain_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits.
REQ-002 The block SHALL have parameter STEPS, default 10, setting the number of additions per job; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid / req1_valid  input  1 each  requester 0/1 has a job.
REQ-006 req0_ready / req1_ready  output  1 each  job of requester 0/1 accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands per requester.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 out_sum  output  WIDTH  job result.
REQ-011 out_id  output  1  requester that owns out_sum.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 The block SHALL time-share one WIDTH-bit adder between two requesters, one job at a time.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
- IDLE->RUN on grant.
- RUN->DONE after the last addition.
- DONE->IDLE when out_valid && out_ready.
REQ-015 Result SHALL be acc0=a+b; acc_k=acc_(k-1)+(k odd ? a : b) for k=1..STEPS-1; out_sum=acc_(STEPS-1) mod 2^WIDTH (STEPS=10: 6a+5b).
REQ-016 Grant on a cycle in IDLE SHALL register a, b, and id, load acc<=a+b and cnt<=1.
- Each RUN cycle performs one addition and increments cnt.
- The addition with cnt==STEPS-1 moves to DONE.
REQ-017 Latency SHALL be exactly STEPS cycles from accept edge to first out_valid=1 cycle.
REQ-018 reqN_ready SHALL be combinational and high only in IDLE for the granted requester, and only when that requester's valid is high; at most one ready is high per cycle.
REQ-019 Arbitration SHALL be round-robin.
- A single requester is granted directly.
- When both request, grant goes to the requester not served last; a 1-bit pointer records the last served requester.
REQ-020 No job SHALL be accepted in RUN or DONE; in DONE, out_sum/out_id SHALL hold stable while out_ready=0.
REQ-021 On DONE with out_ready=1, the next grant SHALL occur no earlier than the following cycle; there is no accept-while-draining.
REQ-022 Operand changes on reqN_* after acceptance SHALL NOT affect the running job.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, out_valid=0, out_sum=0, out_id=0, busy=0, cnt=0, and pointer such that requester 0 wins the first tie, regardless of state.
REQ-024 A job in RUN or DONE at reset SHALL be discarded without out_valid; readies SHALL be 0 while rst=1.

Configuration
REQ-025 Macro ADDCHAIN_OVF_EN SHALL control overflow reporting.
- When ADDCHAIN_OVF_EN is defined, output out_ovf (1 bit) SHALL report a sticky carry-out of any of the job's STEPS additions; it is cleared on grant, valid with out_valid, and 0 on reset.
- When ADDCHAIN_OVF_EN is undefined, port out_ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Basic: req0 with a=1, b=2, out_ready=1 -> out_valid exactly 10 cycles after accept, out_sum=16, out_id=0.
REQ-027 Tie: both valid from reset, req0 a=1 b=1, req1 a=2 b=2 -> req0 served first (sum 11), then req1 (sum 22, id 1); pointer alternates on repeated ties.
REQ-028 Backpressure: out_ready=0 for 5 cycles in DONE -> out_sum/out_id stable, both readies 0; accept resumes the cycle after the out_ready handshake.
REQ-029 Wrap: a=0xFFFFFFFF, b=0 -> out_sum=0xFFFFFFFA; with ADDCHAIN_OVF_EN, out_ovf=1; a=1, b=2 -> out_ovf=0.
REQ-030 Reset mid-job: rst asserted at RUN cnt=4 -> next cycle IDLE, busy=0, no out_valid; a fresh req1 job then completes with correct sum.
REQ-031 Operand hold: change req0_a on the cycle after accept -> result uses the captured value.
